renode_input_event_queue: RTL and testbench
===========================================

RENODE_INPUT_EVENT_QUEUE -- requirements
Module: renode_input_event_queue

Interface
REQ-001 SHALL have parameter InputsCount, default 1: number of monitored GPIO lines, range 1..64.
REQ-002 SHALL have parameter FifoDepth, default 8: event FIFO entries; must be a power of two, 2..64.
REQ-003 SHALL have port clk, input, 1 bit: single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port inputs, input, InputsCount bits: raw GPIO lines from the design.
REQ-006 SHALL have port flush, input, 1 bit: synchronous flush request.
REQ-007 SHALL have port event_valid, output, 1 bit: head event available.
REQ-008 SHALL have port event_ready, input, 1 bit: consumer accepts the head event.
REQ-009 SHALL have port event_index, output, IdxW = max($clog2(InputsCount),1) bits: line number of the head event.
REQ-010 SHALL have port event_value, output, 1 bit: new level of that line.
REQ-011 SHALL have port event_count, output, $clog2(FifoDepth+1) bits: number of queued events.

Function
REQ-012 SHALL register inputs every cycle into sampled[InputsCount-1:0]; with the synchronizer compiled in (REQ-026), sampled is the second stage of a 2-flop chain.
REQ-013 SHALL hold last_reported[InputsCount-1:0], the level last enqueued per line; pending[i] = sampled[i] XOR last_reported[i], combinational.
REQ-014 SHALL select, each cycle, the lowest-index line with pending set; enqueue when any pending, FIFO not full (or a pop happens in the same cycle) and flush low.
REQ-015 On enqueue: write {index, sampled[index]} at the write pointer and set last_reported[index] := sampled[index] on the same edge; at most one enqueue per cycle.
REQ-016 A line that toggles and returns before it is enqueued SHALL produce no event; an event SHALL always carry the level at enqueue time, not at change time.
REQ-017 A full FIFO SHALL backpressure: pending lines wait, no event is dropped and no overflow state exists.
REQ-018 FIFO SHALL be first-word-fall-through: event_valid = count != 0; event_index/event_value show the head entry combinationally from storage.
REQ-019 Pop SHALL occur on a clock edge where event_valid and event_ready are both high; event_ready with event_valid low SHALL have no effect.
REQ-020 Simultaneous push and pop SHALL leave count unchanged. This applies when full (pop frees the slot) and when count = 1.
REQ-021 Push into an empty FIFO SHALL NOT bypass: event_valid rises one edge after the write.
REQ-022 Pointers SHALL be log2(FifoDepth) bits wide and wrap modulo FifoDepth; count SHALL be kept explicitly, range 0..FifoDepth.
REQ-023 Latency without the synchronizer: a pin change set up before edge E is sampled at E, enqueued at E+1, and event_valid is high after E+1. With the synchronizer, add one edge.
REQ-024 While flush is high: set pointers and count to 0, set last_reported := sampled, perform no enqueue, ignore pops. Current levels are therefore treated as already reported.

Reset
REQ-025 While rst_n is low, regardless of clk: FIFO empty, count 0, event_valid 0, sampled 0, synchronizer flops 0, last_reported 0. After release, any line at 1 SHALL produce an event once sampled.

Configuration
REQ-026 Macro RENODE_INPUT_SYNC_EN: when defined, a 2-flop synchronizer sits before the comparison (REQ-012, +1 cycle latency). When undefined, a single sample register only, for lines already synchronous to clk.

Verification
REQ-027 InputsCount=4, no macro: after reset, drive inputs=4'b0000->4'b0101 before edge E -> after E+1 event {0,1}, after E+2 second event {2,1}, event_ready held 1, count returns to 0.
REQ-028 FifoDepth=4, event_ready=0, toggle line 0 five times with gaps of 3 cycles -> count saturates at 4, last_reported[0] reflects the 4th enqueue, and no event is lost on release: events alternate 1,0,1,0, then the final level is enqueued after the first pop.
REQ-029 Line 1 high for one cycle while the FIFO is full and line 1 is pending -> no event for line 1 once drained.
REQ-030 Full FIFO, event_ready=1 and a new pending line in the same cycle -> count stays 4, head advances, new event lands at tail.
REQ-031 Flush asserted with count=3 and inputs=4'b1111 -> count 0 next edge, no further events while inputs are static; then drop line 3 -> event {3,0}.
REQ-032 rst_n pulsed low mid-stream with count=2 -> event_valid 0 immediately (asynchronous); after release with inputs=4'b0010 -> single event {1,1}; with RENODE_INPUT_SYNC_EN, same result one cycle later.

Source files
------------

// File: rtl/renode_input_event_queue.sv
// GPIO change-event queue: each monitored line that differs from its last reported level
// is queued as {index, level} in a first-word-fall-through FIFO, lowest index first.
// Optional build macro RENODE_INPUT_SYNC_EN adds a 2-flop synchronizer ahead of sampling.
module renode_input_event_queue #(
   parameter int InputsCount = 1,
   parameter int FifoDepth   = 8,
   localparam int IdxW = (InputsCount > 1) ? $clog2(InputsCount) : 1,
   localparam int PtrW = $clog2(FifoDepth),
   localparam int CntW = $clog2(FifoDepth + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [InputsCount-1:0] inputs,
   input  logic                   flush,
   output logic                   event_valid,
   input  logic                   event_ready,
   output logic [IdxW-1:0]        event_index,
   output logic                   event_value,
   output logic [CntW-1:0]        event_count
);

   logic [InputsCount-1:0] sampled_q;
   logic [InputsCount-1:0] lastReported_q, lastReported_d;
   logic [InputsCount-1:0] pending;
   logic [PtrW-1:0]        wrPtr_q, wrPtr_d;
   logic [PtrW-1:0]        rdPtr_q, rdPtr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic [IdxW-1:0]        memIdx_q [FifoDepth];
   logic                   memVal_q [FifoDepth];

   logic            anyPending;
   logic [IdxW-1:0] selIdx;
   logic            selValue;
   logic            full;
   logic            push;
   logic            pop;

`ifdef RENODE_INPUT_SYNC_EN
   logic [InputsCount-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         sampled_q <= '0;
      end else begin
         sync_q    <= inputs;
         sampled_q <= sync_q;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sampled_q <= '0;
      end else begin
         sampled_q <= inputs;
      end
   end
`endif

   assign pending = sampled_q ^ lastReported_q;

   // Scan downwards so the lowest pending index is the one left selected.
   always_comb begin
      anyPending = 1'b0;
      selIdx     = '0;
      selValue   = 1'b0;
      for (int i = InputsCount - 1; i >= 0; i--) begin
         if (pending[i]) begin
            anyPending = 1'b1;
            selIdx     = IdxW'(i);
            selValue   = sampled_q[i];
         end
      end
   end

   assign full        = (count_q == CntW'(FifoDepth));
   assign event_valid = (count_q != '0);
   assign pop         = event_valid & event_ready & ~flush;
   assign push        = anyPending & (~full | pop) & ~flush;

   // Flush discards the queue and treats the current levels as already reported.
   always_comb begin
      count_d        = count_q;
      wrPtr_d        = wrPtr_q;
      rdPtr_d        = rdPtr_q;
      lastReported_d = lastReported_q;
      if (flush) begin
         count_d        = '0;
         wrPtr_d        = '0;
         rdPtr_d        = '0;
         lastReported_d = sampled_q;
      end else begin
         if (push) begin
            wrPtr_d                = wrPtr_q + PtrW'(1);
            lastReported_d[selIdx] = selValue;
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PtrW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q        <= '0;
         wrPtr_q        <= '0;
         rdPtr_q        <= '0;
         lastReported_q <= '0;
      end else begin
         count_q        <= count_d;
         wrPtr_q        <= wrPtr_d;
         rdPtr_q        <= rdPtr_d;
         lastReported_q <= lastReported_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FifoDepth; i++) begin
            memIdx_q[i] <= '0;
            memVal_q[i] <= 1'b0;
         end
      end else if (push) begin
         memIdx_q[wrPtr_q] <= selIdx;
         memVal_q[wrPtr_q] <= selValue;
      end
   end

   assign event_index = memIdx_q[rdPtr_q];
   assign event_value = memVal_q[rdPtr_q];
   assign event_count = count_q;

endmodule

// File: tb/tb_renode_input_event_queue.sv
// Testbench for renode_input_event_queue (4 lines, 4-entry FIFO): fixed vector table,
// directed corner sequences and randomized traffic against a queue-based reference model.
module tb_renode_input_event_queue;

   localparam int Inputs = 4;
   localparam int Depth  = 4;
   localparam int IdxW   = 2;
   localparam int CntW   = 3;
`ifdef RENODE_INPUT_SYNC_EN
   localparam int SyncLat = 1;
`else
   localparam int SyncLat = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [Inputs-1:0] inputsT;
   logic              flushT;
   logic              readyT;
   logic              eventValid;
   logic [IdxW-1:0]   eventIndex;
   logic              eventValue;
   logic [CntW-1:0]   eventCount;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [IdxW-1:0] idx;
      logic            val;
   } ev_t;

   // Reference model: event queue plus delayed copies of the input lines.
   ev_t               evQ[$];
   logic [Inputs-1:0] syncM;
   logic [Inputs-1:0] sampM;
   logic [Inputs-1:0] lastM;

   typedef struct {
      logic [3:0] in;
      logic       expValid;
      logic [2:0] expCount;
      logic [1:0] expIdx;
      logic       expVal;
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   renode_input_event_queue #(
      .InputsCount(Inputs),
      .FifoDepth  (Depth)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inputs     (inputsT),
      .flush      (flushT),
      .event_valid(eventValid),
      .event_ready(readyT),
      .event_index(eventIndex),
      .event_value(eventValue),
      .event_count(eventCount)
   );

   task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      evQ.delete();
      syncM = '0;
      sampM = '0;
      lastM = '0;
   endtask

   // One clock edge of the model, using the state as it stood just before the edge.
   task automatic modelStep(input logic [3:0] in, input logic rdy, input logic fl);
      int                sel;
      bit                popM;
      bit                pushM;
      logic [Inputs-1:0] pend;
      ev_t               e;
      pend = sampM ^ lastM;
      sel  = -1;
      for (int i = 0; i < Inputs; i++) begin
         if (pend[i] && sel < 0) sel = i;
      end
      popM  = (evQ.size() != 0) && rdy && !fl;
      pushM = (sel >= 0) && ((evQ.size() < Depth) || popM) && !fl;
      if (fl) begin
         evQ.delete();
         lastM = sampM;
      end else begin
         if (popM) void'(evQ.pop_front());
         if (pushM) begin
            e.idx = IdxW'(sel);
            e.val = sampM[sel];
            evQ.push_back(e);
            lastM[sel] = sampM[sel];
         end
      end
      if (SyncLat != 0) begin
         sampM = syncM;
         syncM = in;
      end else begin
         sampM = in;
      end
   endtask

   task automatic checkOutput();
      compare("model_valid", eventValid, (evQ.size() != 0));
      compare("model_count", eventCount, evQ.size());
      if (evQ.size() != 0) begin
         compare("model_index", eventIndex, evQ[0].idx);
         compare("model_value", eventValue, evQ[0].val);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] in, input logic rdy, input logic fl);
      inputsT = in;
      readyT  = rdy;
      flushT  = fl;
      modelStep(in, rdy, fl);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      inputsT = '0;
      readyT  = 1'b0;
      flushT  = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      compare("reset_valid", eventValid, 1'b0);
      compare("reset_count", eventCount, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);
   endtask

   // Leaves the FIFO full with line-0 events 1,0,1,0 and line 0 back at 0.
   task automatic fillWithToggles();
      logic [3:0] in;
      in = 4'b0000;
      for (int t = 0; t < 4; t++) begin
         in[0] = ~in[0];
         repeat (3) applyStimulus(in, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] in;
      vec_t       e;
      int         line1Seen;
      int         drained;
      ev_t        expDrain[4];
      logic       expSeq[5];

      // Two-line change followed by a single drop and a three-line change, ready held high.
      tbl[0]  = '{4'b0101, 1'b0, 3'd0, 2'd0, 1'b0};
      tbl[1]  = '{4'b0101, 1'b1, 3'd1, 2'd0, 1'b1};
      tbl[2]  = '{4'b0101, 1'b1, 3'd1, 2'd2, 1'b1};
      tbl[3]  = '{4'b0101, 1'b0, 3'd0, 2'd0, 1'b0};
      tbl[4]  = '{4'b0001, 1'b0, 3'd0, 2'd0, 1'b0};
      tbl[5]  = '{4'b0001, 1'b1, 3'd1, 2'd2, 1'b0};
      tbl[6]  = '{4'b0001, 1'b0, 3'd0, 2'd0, 1'b0};
      tbl[7]  = '{4'b1010, 1'b0, 3'd0, 2'd0, 1'b0};
      tbl[8]  = '{4'b1010, 1'b1, 3'd1, 2'd0, 1'b0};
      tbl[9]  = '{4'b1010, 1'b1, 3'd1, 2'd1, 1'b1};
      tbl[10] = '{4'b1010, 1'b1, 3'd1, 2'd3, 1'b1};
      tbl[11] = '{4'b1010, 1'b0, 3'd0, 2'd0, 1'b0};

      doReset();
      repeat (2) applyStimulus(4'b0000, 1'b1, 1'b0);

      // With the synchronizer every table expectation lands one edge later.
      for (int k = 0; k < 12; k++) begin
         applyStimulus(tbl[k].in, 1'b1, 1'b0);
         if (SyncLat != 0 && k == 0) e = '{4'b0000, 1'b0, 3'd0, 2'd0, 1'b0};
         else e = tbl[k - SyncLat];
         compare($sformatf("tbl%0d_valid", k), eventValid, e.expValid);
         compare($sformatf("tbl%0d_count", k), eventCount, e.expCount);
         if (e.expValid) begin
            compare($sformatf("tbl%0d_index", k), eventIndex, e.expIdx);
            compare($sformatf("tbl%0d_value", k), eventValue, e.expVal);
         end
      end

      // Five toggles into a 4-deep queue: the fifth level waits and follows the first pop.
      doReset();
      in = 4'b0000;
      for (int t = 0; t < 5; t++) begin
         in[0] = ~in[0];
         repeat (3) applyStimulus(in, 1'b0, 1'b0);
      end
      repeat (2) applyStimulus(in, 1'b0, 1'b0);
      compare("sat_count", eventCount, 4);
      expSeq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         compare($sformatf("sat_valid%0d", k), eventValid, 1'b1);
         compare($sformatf("sat_index%0d", k), eventIndex, 0);
         compare($sformatf("sat_value%0d", k), eventValue, expSeq[k]);
         applyStimulus(in, 1'b1, 1'b0);
      end
      compare("sat_empty", eventCount, 0);

      // A one-cycle glitch on line 1 while the queue is full must never be reported.
      doReset();
      fillWithToggles();
      applyStimulus(4'b0010, 1'b0, 1'b0);
      repeat (4) applyStimulus(4'b0000, 1'b0, 1'b0);
      line1Seen = 0;
      drained   = 0;
      for (int k = 0; k < 8; k++) begin
         if (eventValid) begin
            drained++;
            if (eventIndex == 2'd1) line1Seen++;
         end
         applyStimulus(4'b0000, 1'b1, 1'b0);
      end
      compare("glitch_line1_events", line1Seen, 0);
      compare("glitch_drained", drained, 4);
      compare("glitch_empty", eventCount, 0);

      // Full queue with a pop and a new pending line on the same edge.
      doReset();
      fillWithToggles();
      repeat (3) applyStimulus(4'b0100, 1'b0, 1'b0);
      compare("fullpop_before", eventCount, 4);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      compare("fullpop_count", eventCount, 4);
      compare("fullpop_head_value", eventValue, 1'b0);
      expDrain = '{'{2'd0, 1'b0}, '{2'd0, 1'b1}, '{2'd0, 1'b0}, '{2'd2, 1'b1}};
      for (int k = 0; k < 4; k++) begin
         compare($sformatf("fullpop_index%0d", k), eventIndex, expDrain[k].idx);
         compare($sformatf("fullpop_value%0d", k), eventValue, expDrain[k].val);
         applyStimulus(4'b0100, 1'b1, 1'b0);
      end
      compare("fullpop_empty", eventCount, 0);

      // Flush with three queued events and a fourth still pending.
      doReset();
      repeat (4 + SyncLat) applyStimulus(4'b1111, 1'b0, 1'b0);
      compare("flush_pre_count", eventCount, 3);
      applyStimulus(4'b1111, 1'b0, 1'b1);
      compare("flush_count", eventCount, 0);
      repeat (5) applyStimulus(4'b1111, 1'b1, 1'b0);
      compare("flush_static_count", eventCount, 0);
      repeat (2 + SyncLat) applyStimulus(4'b0111, 1'b0, 1'b0);
      compare("flush_drop_count", eventCount, 1);
      compare("flush_drop_index", eventIndex, 3);
      compare("flush_drop_value", eventValue, 1'b0);

      // Asynchronous reset in the middle of traffic.
      doReset();
      repeat (3 + SyncLat) applyStimulus(4'b0011, 1'b0, 1'b0);
      compare("areset_pre_count", eventCount, 2);
      #2;
      rst_n = 1'b0;
      #1;
      compare("areset_valid_now", eventValid, 1'b0);
      compare("areset_count_now", eventCount, 0);
      modelReset();
      inputsT = 4'b0010;
      @(posedge clk);
      #1;
      compare("areset_valid_held", eventValid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 + SyncLat) applyStimulus(4'b0010, 1'b0, 1'b0);
      compare("areset_event_count", eventCount, 1);
      compare("areset_event_index", eventIndex, 1);
      compare("areset_event_value", eventValue, 1'b1);
      repeat (3) applyStimulus(4'b0010, 1'b0, 1'b0);
      compare("areset_single", eventCount, 1);

      // Randomized traffic, checked every edge against the model.
      doReset();
      in = 4'b0000;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) < 3) in = 4'($urandom_range(0, 15));
         applyStimulus(in, ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
